data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arb_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/data_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the two-port data memory arbiter:
// controller state encoding and default memory geometry.
package data_mem_arb_pkg;

  localparam int MEM_BYTES_DEF  = 512;
  localparam int WORD_BYTES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone request wins outright; on a tie the
// port that was not granted most recently wins. Port 0 is favoured after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_idx,
  output logic       any_req
);

  logic prefer1_q;

  always_comb begin
    any_req   = |req;
    grant_idx = 1'b0;
    if (req == 2'b10) begin
      grant_idx = 1'b1;
    end else if (req == 2'b11) begin
      grant_idx = prefer1_q;
    end
  end

  // Every accepted grant hands priority to the other port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prefer1_q <= 1'b0;
    end else if (accept && any_req) begin
      prefer1_q <= ~grant_idx;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a load/store port and a loader/debug port onto one data memory
// with a fixed IDLE -> ACCESS -> RESP sequence per transaction.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int MEM_BYTES  = MEM_BYTES_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);

  arb_state_t  state_q, state_d;
  logic        sel_q, we_q, err_q;
  logic [63:0] addr_q, wdata_q;

  logic        win_idx, any_req, accept;
  logic        win_we, win_err;
  logic [63:0] win_addr, win_wdata;

  assign accept = (state_q == IDLE);

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       ({req1, req0}),
    .accept    (accept),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  // The bound check uses a 65-bit sum so addresses near 2^64 cannot wrap
  // back into range.
  always_comb begin
    win_we    = win_idx ? we1 : we0;
    win_addr  = win_idx ? addr1 : addr0;
    win_wdata = win_idx ? wdata1 : wdata0;
    win_err   = (({1'b0, win_addr} + 65'(WORD_BYTES)) > 65'(MEM_BYTES)) ||
                ((win_addr % 64'(WORD_BYTES)) != 64'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All handshake and memory outputs decode from registered state only,
  // so an asynchronous reset clears them at once.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == ACCESS) begin
      gnt0      = ~sel_q;
      gnt1      = sel_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_read  = ~err_q & ~we_q;
      mem_write = ~err_q & we_q;
    end
    if (state_q == RESP) begin
      done0 = ~sel_q;
      done1 = sel_q;
      err0  = ~sel_q & err_q;
      err1  = sel_q & err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata0  <= 64'd0;
      rdata1  <= 64'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        sel_q   <= win_idx;
        we_q    <= win_we;
        err_q   <= win_err;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
      // Faulted accesses report zero data whether they were reads or writes.
      if (state_q == ACCESS && (err_q || !we_q)) begin
        if (sel_q) begin
          rdata1 <= err_q ? 64'd0 : mem_rdata;
        end else begin
          rdata0 <= err_q ? 64'd0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push expected
// completions, a negedge monitor pops and compares on every done pulse.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clk, reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [63:0] rdata0, rdata1;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [63:0] mem [0:63];
  exp_t        exp_q[$];
  int          total_checks = 0;
  int          fail_count   = 0;
  int          rd_count     = 0;
  int          wr_count     = 0;

  data_mem_arbiter #(.MEM_BYTES(512), .WORD_BYTES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model with combinational read.
  assign mem_rdata = mem[mem_addr[8:3]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[8:3]] <= mem_wdata;
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: strobe accounting, idle-bus check, and scoreboard pops on done.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_read)  rd_count++;
      if (mem_write) wr_count++;
      if (!gnt0 && !gnt1)
        check_output("idle_mem_bus", {mem_addr | mem_wdata} | {62'd0, mem_read, mem_write}, 64'd0);
      if (done0 || done1) begin
        check_output("done_onehot", {62'd0, done1, done0} & {62'd0, done0, done1}, 64'd0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", {62'd0, done1, done0}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("done_port", {63'd0, done1}, {63'd0, e.port});
          check_output("err", {63'd0, e.port ? err1 : err0}, {63'd0, e.err});
          check_output("rdata", e.port ? rdata1 : rdata0, e.rdata);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic port, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic exp_err,
                                input logic [63:0] exp_rdata);
    int rd0, wr0, waited;
    bit seen;
    rd0 = rd_count;
    wr0 = wr_count;
    exp_q.push_back('{port, exp_err, exp_rdata});
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    seen = 1'b0;
    waited = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (port ? gnt1 : gnt0) begin
        seen = 1'b1;
        waited = i;
      end
    end
    check_output("gnt_seen", {63'd0, seen}, 64'd1);
    check_output("gnt_latency", 64'(waited), 64'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("read_strobes", 64'(rd_count - rd0), {63'd0, !we && !exp_err});
    check_output("write_strobes", 64'(wr_count - wr0), {63'd0, we && !exp_err});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd_snap;
    for (int i = 0; i < 64; i++) mem[i] = 64'd0;
    mem[32] = 64'd6;
    mem[63] = 64'hABCD;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 64'd0; addr1 = 64'd0; wdata0 = 64'd0; wdata1 = 64'd0;

    @(negedge clk);
    @(negedge clk);
    check_output("rst_handshake", {58'd0, gnt0, gnt1, done0, done1, err0, err1}, 64'd0);
    check_output("rst_rdata", rdata0 | rdata1, 64'd0);
    check_output("rst_mem", {mem_addr | mem_wdata} | {62'd0, mem_read, mem_write}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] port 0 read");
    apply_stimulus(1'b0, 1'b0, 64'd256, 64'd0, 1'b0, 64'd6);

    $display("[TB] port 1 write then read");
    apply_stimulus(1'b1, 1'b1, 64'd264, 64'h1234, 1'b0, 64'd0);
    check_output("mem_after_write", mem[33], 64'h1234);
    apply_stimulus(1'b1, 1'b0, 64'd264, 64'd0, 1'b0, 64'h1234);

    $display("[TB] contention");
    exp_q.push_back('{1'b0, 1'b0, 64'd6});
    exp_q.push_back('{1'b1, 1'b0, 64'h1234});
    exp_q.push_back('{1'b0, 1'b0, 64'd6});
    exp_q.push_back('{1'b1, 1'b0, 64'h1234});
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd256;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd264;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_output("contention_gnt", {62'd0, gnt1, gnt0},
                   (i % 3 != 0) ? 64'd0 : (((i / 3) % 2 == 0) ? 64'd1 : 64'd2));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] address errors and boundary");
    apply_stimulus(1'b0, 1'b0, 64'd510, 64'd0, 1'b1, 64'd0);
    apply_stimulus(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 64'd0);
    apply_stimulus(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 64'd0);
    apply_stimulus(1'b0, 1'b1, 64'd512, 64'h55, 1'b1, 64'd0);
    apply_stimulus(1'b0, 1'b0, 64'd504, 64'd0, 1'b0, 64'hABCD);

    $display("[TB] reset during access");
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd256;
    @(negedge clk);
    check_output("pre_reset_gnt0", {63'd0, gnt0}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_output("reset_outputs", {58'd0, gnt0, gnt1, done0, done1, mem_read, mem_write}, 64'd0);
    check_output("reset_mem_addr", mem_addr, 64'd0);
    req0 = 1'b0;
    rd_snap = rd_count;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("no_strobe_after_reset", 64'(rd_count - rd_snap), 64'd0);

    exp_q.push_back('{1'b0, 1'b0, 64'd6});
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'd256;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd264;
    @(negedge clk);
    check_output("post_reset_gnt", {62'd0, gnt1, gnt0}, 64'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
